// File: rtl/io_trigger_sequencer_pkg.sv
// Shared definitions for the IO trigger sequencer.
//   seq_state_t      : sequencer FSM states
//   TRIG_TERMINATOR  : all-ones word that ends a trigger_system state table
//   ENTRY_*          : field positions inside an 18-bit pattern entry
//   HIGH_INF         : "no upper bound" value for the HIGH field
//   make_entry()     : packs {state, high, low} into one pattern entry
package io_trigger_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_TERM    = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_ARMED   = 3'd4,
        ST_HOLDOFF = 3'd5
    } seq_state_t;

    localparam logic [17:0] TRIG_TERMINATOR = 18'h3FFFF;

    localparam int unsigned ENTRY_LOW_LSB   = 0;
    localparam int unsigned ENTRY_LOW_MSB   = 7;
    localparam int unsigned ENTRY_HIGH_LSB  = 8;
    localparam int unsigned ENTRY_HIGH_MSB  = 16;
    localparam int unsigned ENTRY_STATE_BIT = 17;

    localparam logic [8:0] HIGH_INF = 9'd511;

    function automatic logic [17:0] make_entry(input logic st, input logic [8:0] high,
                                               input logic [7:0] low);
        logic [17:0] e;
        e = '0;
        e[ENTRY_STATE_BIT]                = st;
        e[ENTRY_HIGH_MSB:ENTRY_HIGH_LSB]  = high;
        e[ENTRY_LOW_MSB:ENTRY_LOW_LSB]    = low;
        return e;
    endfunction

endpackage

// File: rtl/io_trigger_sequencer_seq_cycle_timer.sv
// Loadable down-counter used for settle, holdoff and armed-timeout intervals.
//   clk, rst    : clock, asynchronous active-high reset
//   load        : load load_value (takes priority over counting)
//   load_value  : interval length in cycles; 0 never raises done
//   done        : high during the last cycle of the loaded interval
module seq_cycle_timer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] remaining;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining <= '0;
        end else if (load) begin
            remaining <= load_value;
        end else if (remaining != '0) begin
            remaining <= remaining - 1'b1;
        end
    end

    // Loaded at the edge that enters the interval, so a value of N makes
    // done appear in the N-th cycle of that interval.
    assign done = (remaining == WIDTH'(1));

endmodule

// File: rtl/io_trigger_sequencer.sv
// Sequencer for the trigger_system pattern engine: loads the state RAM from a
// host entry stream, appends the terminator, settles the engine in reset,
// arms it and gates its trigger output (single shot / continuous).
//   load_start/num_entries/entry_*  : host load interface
//   arm/disarm/continuous           : arming control
//   holdoff_cycles/timeout_cycles   : continuous-mode dead time, armed timeout
//   state_prog_*                    : state RAM programming port
//   ts_rst/ts_trig                  : engine reset and raw trigger
//   trig_out, busy, armed, triggered, timed_out, trig_count : status
module io_trigger_sequencer
    import io_trigger_sequencer_pkg::*;
#(
    parameter int unsigned STATEADDR_WIDTH  = 6,
    parameter int unsigned STATEADDR_STATES = 64,
    parameter int unsigned SETTLE_CYCLES    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_start,
    input  logic [STATEADDR_WIDTH-1:0] num_entries,
    input  logic                       entry_valid,
    output logic                       entry_ready,
    input  logic [17:0]                entry_data,
    input  logic                       arm,
    input  logic                       disarm,
    input  logic                       continuous,
    input  logic [15:0]                holdoff_cycles,
    input  logic [31:0]                timeout_cycles,
    output logic                       state_prog_en,
    output logic [STATEADDR_WIDTH-1:0] state_prog_addr,
    output logic                       state_prog_wr,
    output logic [17:0]                state_prog_data,
    output logic                       ts_rst,
    input  logic                       ts_trig,
    output logic                       trig_out,
    output logic                       busy,
    output logic                       armed,
    output logic                       triggered,
    output logic                       timed_out,
    output logic [15:0]                trig_count
);

    localparam logic [STATEADDR_WIDTH-1:0] MAX_ENTRIES = STATEADDR_WIDTH'(STATEADDR_STATES - 1);

    seq_state_t                 state_q, state_d;
    logic                       settle_to_armed;
    logic [STATEADDR_WIDTH-1:0] wr_addr, entry_count, load_count;
    logic                       start_load, start_arm, accept, term_wr;
    logic                       trig_fire, timeout_fire;
    logic                       timer_load, timer_done;
    logic [31:0]                timer_value, holdoff_len;

    assign start_load = (state_q == ST_IDLE) && load_start;
    assign start_arm  = (state_q == ST_IDLE) && !load_start && arm;
    assign load_count = (32'(num_entries) > STATEADDR_STATES - 1) ? MAX_ENTRIES : num_entries;

    assign entry_ready  = (state_q == ST_LOAD) && (wr_addr < entry_count);
    assign accept       = entry_ready && entry_valid;
    assign term_wr      = (state_q == ST_TERM) && !disarm;
    // disarm beats the trigger, and the trigger beats the timeout
    assign trig_fire    = (state_q == ST_ARMED) && ts_trig && !disarm;
    assign timeout_fire = (state_q == ST_ARMED) && timer_done && !ts_trig && !disarm;

    // One extra holdoff cycle covers the trig_out cycle, during which ts_rst is
    // kept low, so the engine still sees the full max(holdoff, settle) reset.
    assign holdoff_len = ((32'(holdoff_cycles) > 32'(SETTLE_CYCLES)) ?
                          32'(holdoff_cycles) : 32'(SETTLE_CYCLES)) + 32'd1;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (load_start)  state_d = ST_LOAD;
                else if (arm)    state_d = ST_SETTLE;
            end
            ST_LOAD: begin
                if (disarm)                        state_d = ST_IDLE;
                else if (wr_addr == entry_count)   state_d = ST_TERM;
            end
            ST_TERM: state_d = disarm ? ST_IDLE : ST_SETTLE;
            ST_SETTLE: begin
                if (timer_done) state_d = settle_to_armed ? ST_ARMED : ST_IDLE;
            end
            ST_ARMED: begin
                if (disarm)            state_d = ST_IDLE;
                else if (ts_trig)      state_d = continuous ? ST_HOLDOFF : ST_IDLE;
                else if (timer_done)   state_d = ST_IDLE;
            end
            ST_HOLDOFF: begin
                if (disarm)          state_d = ST_IDLE;
                else if (timer_done) state_d = ST_ARMED;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Every timed state is entered through a state change, so the timer is
    // (re)loaded on any transition with the length of the state being entered.
    assign timer_load = (state_d != state_q);

    always_comb begin
        timer_value = '0;
        unique case (state_d)
            ST_SETTLE:  timer_value = 32'(SETTLE_CYCLES);
            ST_HOLDOFF: timer_value = holdoff_len;
            ST_ARMED:   timer_value = timeout_cycles;
            default:    timer_value = '0;
        endcase
    end

    seq_cycle_timer #(.WIDTH(32)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_value (timer_value),
        .done       (timer_done)
    );

    assign state_prog_en   = (state_q == ST_LOAD) || (state_q == ST_TERM);
    assign state_prog_wr   = accept || term_wr;
    assign state_prog_addr = state_prog_en ? wr_addr : '0;
    assign state_prog_data = accept ? entry_data : (term_wr ? TRIG_TERMINATOR : '0);

    assign ts_rst = (state_q != ST_ARMED) && !trig_out;
    assign busy   = (state_q == ST_LOAD) || (state_q == ST_TERM) || (state_q == ST_SETTLE);
    assign armed  = (state_q == ST_ARMED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            settle_to_armed <= 1'b0;
            wr_addr         <= '0;
            entry_count     <= '0;
            trig_out        <= 1'b0;
            triggered       <= 1'b0;
            timed_out       <= 1'b0;
            trig_count      <= '0;
        end else begin
            state_q  <= state_d;
            trig_out <= trig_fire;
            if (start_load) begin
                wr_addr         <= '0;
                entry_count     <= load_count;
                settle_to_armed <= 1'b0;
                triggered       <= 1'b0;
                timed_out       <= 1'b0;
                trig_count      <= '0;
            end else if (start_arm) begin
                settle_to_armed <= 1'b1;
                triggered       <= 1'b0;
                timed_out       <= 1'b0;
            end
            if (accept) wr_addr <= wr_addr + 1'b1;
            if (trig_fire) begin
                triggered <= 1'b1;
                if (trig_count != '1) trig_count <= trig_count + 1'b1;
            end
            if (timeout_fire) timed_out <= 1'b1;
        end
    end

endmodule

// File: tb/tb_io_trigger_sequencer.sv
module tb_io_trigger_sequencer;
    import io_trigger_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0;
    logic [5:0]  num_entries = '0;
    logic        entry_valid = 1'b0;
    logic        entry_ready;
    logic [17:0] entry_data = '0;
    logic        arm = 1'b0;
    logic        disarm = 1'b0;
    logic        continuous = 1'b0;
    logic [15:0] holdoff_cycles = '0;
    logic [31:0] timeout_cycles = '0;
    logic        state_prog_en;
    logic [5:0]  state_prog_addr;
    logic        state_prog_wr;
    logic [17:0] state_prog_data;
    logic        ts_rst;
    logic        ts_trig = 1'b0;
    logic        trig_out;
    logic        busy;
    logic        armed;
    logic        triggered;
    logic        timed_out;
    logic [15:0] trig_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    io_trigger_sequencer #(
        .STATEADDR_WIDTH  (6),
        .STATEADDR_STATES (64),
        .SETTLE_CYCLES    (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .load_start      (load_start),
        .num_entries     (num_entries),
        .entry_valid     (entry_valid),
        .entry_ready     (entry_ready),
        .entry_data      (entry_data),
        .arm             (arm),
        .disarm          (disarm),
        .continuous      (continuous),
        .holdoff_cycles  (holdoff_cycles),
        .timeout_cycles  (timeout_cycles),
        .state_prog_en   (state_prog_en),
        .state_prog_addr (state_prog_addr),
        .state_prog_wr   (state_prog_wr),
        .state_prog_data (state_prog_data),
        .ts_rst          (ts_rst),
        .ts_trig         (ts_trig),
        .trig_out        (trig_out),
        .busy            (busy),
        .armed           (armed),
        .triggered       (triggered),
        .timed_out       (timed_out),
        .trig_count      (trig_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; returns 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [17:0] pattern(input int k);
        logic [8:0] hi;
        hi = (k == 1) ? HIGH_INF : 9'(k * 5 + 1);
        return make_entry(k[0], hi, 8'(k * 7 + 3));
    endfunction

    // Runs a full load from IDLE; returns pattern writes seen, bad writes
    // (wrong address/data/handshake), terminator address and SETTLE length.
    task automatic load_entries(input int n, input bit stall, output int writes,
                                output int bad, output int term_at, output int settle);
        writes = 0; bad = 0; term_at = -1; settle = 0;
        num_entries = 6'(n);
        load_start  = 1'b1;
        step();
        load_start  = 1'b0;
        for (int c = 0; c < 400 && term_at < 0; c++) begin
            entry_valid = stall ? c[0] : 1'b1;
            entry_data  = pattern(writes);
            #1;
            if (state_prog_wr) begin
                if (state_prog_data == TRIG_TERMINATOR) begin
                    term_at = int'(state_prog_addr);
                end else begin
                    if (int'(state_prog_addr) != writes || !entry_ready || !state_prog_en ||
                        state_prog_data != pattern(writes)) bad++;
                    writes++;
                end
            end
            step();
        end
        entry_valid = 1'b0;
        while (busy && settle < 40) begin
            settle++;
            step();
        end
    endtask

    task automatic wait_armed(output int n);
        n = 0;
        while (!armed && n < 50) begin
            n++;
            step();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w, b, t, s, n;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ts_rst", ts_rst, 1);
        check_eq("rst_trig_out", trig_out, 0);
        check_eq("rst_entry_ready", entry_ready, 0);
        check_eq("rst_prog", {state_prog_en, state_prog_wr, state_prog_addr, state_prog_data}, 0);
        check_eq("rst_status", {busy, armed, triggered, timed_out}, 0);
        check_eq("rst_trig_count", trig_count, 0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // three entries, valid every other cycle
        load_entries(3, 1'b1, w, b, t, s);
        check_eq("load3_writes", w, 3);
        check_eq("load3_bad", b, 0);
        check_eq("load3_term_addr", t, 3);
        check_eq("load3_settle", s, 4);
        check_eq("load3_idle_ts_rst", ts_rst, 1);

        // full table and empty table
        load_entries(63, 1'b0, w, b, t, s);
        check_eq("load63_writes", w, 63);
        check_eq("load63_bad", b, 0);
        check_eq("load63_term_addr", t, 63);
        load_entries(0, 1'b0, w, b, t, s);
        check_eq("load0_writes", w, 0);
        check_eq("load0_term_addr", t, 0);

        // single shot
        continuous = 1'b0; timeout_cycles = 0;
        arm = 1'b1; step(); arm = 1'b0;
        wait_armed(n);
        check_eq("ss_settle", n, 4);
        check_eq("ss_armed_ts_rst", ts_rst, 0);
        repeat (9) step();
        ts_trig = 1'b1; #1;
        check_eq("ss_no_early_trig", trig_out, 0);
        step(); ts_trig = 1'b0;
        check_eq("ss_trig_out", trig_out, 1);
        check_eq("ss_triggered", triggered, 1);
        check_eq("ss_trig_count", trig_count, 1);
        check_eq("ss_state_idle", {busy, armed}, 0);
        step();
        check_eq("ss_trig_pulse_end", trig_out, 0);
        check_eq("ss_idle_ts_rst", ts_rst, 1);

        // continuous with holdoff 20 (fresh load clears the count)
        load_entries(0, 1'b0, w, b, t, s);
        check_eq("cont_count_clear", trig_count, 0);
        continuous = 1'b1; holdoff_cycles = 16'd20;
        arm = 1'b1; step(); arm = 1'b0;
        wait_armed(n);
        ts_trig = 1'b1; step(); ts_trig = 1'b0;
        check_eq("cont_trig1", trig_out, 1);
        check_eq("cont_left_armed", armed, 0);
        repeat (4) step();
        ts_trig = 1'b1; #1;
        check_eq("cont_holdoff_ts_rst", ts_rst, 1);
        step(); ts_trig = 1'b0;
        check_eq("cont_holdoff_no_trig", trig_out, 0);
        wait_armed(n);
        check_eq("cont_holdoff_rest", n, 16);
        ts_trig = 1'b1; step(); ts_trig = 1'b0;
        check_eq("cont_trig3", trig_out, 1);
        check_eq("cont_trig_count", trig_count, 2);
        disarm = 1'b1; step(); disarm = 1'b0;
        check_eq("cont_disarm_idle", {busy, armed, ts_rst}, 3'b001);
        continuous = 1'b0;

        // timeout 100, no trigger
        timeout_cycles = 32'd100;
        arm = 1'b1; step(); arm = 1'b0;
        wait_armed(n);
        n = 0;
        while (armed && n < 300) begin
            n++;
            step();
        end
        check_eq("to_armed_cycles", n, 100);
        check_eq("to_timed_out", timed_out, 1);
        check_eq("to_triggered", triggered, 0);
        check_eq("to_idle", {busy, armed, ts_rst}, 3'b001);

        // trigger on the timeout cycle wins
        arm = 1'b1; step(); arm = 1'b0;
        wait_armed(n);
        repeat (99) step();
        ts_trig = 1'b1; step(); ts_trig = 1'b0;
        check_eq("to_race_trig_out", trig_out, 1);
        check_eq("to_race_flags", {triggered, timed_out}, 2'b10);
        check_eq("to_race_count", trig_count, 3);

        // disarm together with ts_trig
        timeout_cycles = 0;
        arm = 1'b1; step(); arm = 1'b0;
        wait_armed(n);
        ts_trig = 1'b1; disarm = 1'b1; step(); ts_trig = 1'b0; disarm = 1'b0;
        check_eq("dis_trig_out", trig_out, 0);
        check_eq("dis_state", {busy, armed, ts_rst, triggered}, 4'b0010);
        step();
        check_eq("dis_trig_out_later", trig_out, 0);
        check_eq("dis_trig_count", trig_count, 3);

        // asynchronous reset in the middle of a load
        num_entries = 6'd5; load_start = 1'b1; step(); load_start = 1'b0;
        entry_valid = 1'b1; entry_data = pattern(0);
        step(); step();
        #1;
        check_eq("pre_rst_loading", {busy, entry_ready, state_prog_en}, 3'b111);
        #1;
        rst = 1'b1;
        #1;
        check_eq("arst_ready", entry_ready, 0);
        check_eq("arst_prog", {state_prog_en, state_prog_wr, state_prog_addr, state_prog_data}, 0);
        check_eq("arst_status", {busy, armed, ts_rst, trig_out}, 4'b0010);
        entry_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/io_trigger_sequencer.md
Name: io_trigger_sequencer

Overview:
Controls the IO pattern-trigger engine (trigger_system). It loads the state RAM from a host entry stream and writes the all-ones terminator word. It then holds the engine in reset while it settles, arms it, and gates trig_out into single-shot or continuous triggers with holdoff, timeout and trigger counting.

Parameters:
STATEADDR_WIDTH, 6, state RAM address width; matches trigger_system stateaddr_width
STATEADDR_STATES, 64, state RAM depth; at most STATEADDR_STATES-1 pattern entries plus 1 terminator
SETTLE_CYCLES, 4, cycles ts_rst is held after programming or re-arm (minimum 2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
load_start  in  1  1-cycle pulse; begins a load of num_entries words
num_entries  in  STATEADDR_WIDTH  number of pattern words to load
entry_valid  in  1  host entry valid
entry_ready  out  1  sequencer accepts the entry this cycle
entry_data  in  18  {state, high[8:0], low[7:0]} pattern word
arm  in  1  1-cycle pulse; arm the engine
disarm  in  1  1-cycle pulse; abort arming, holdoff or load
continuous  in  1  1 = re-arm after each trigger; 0 = single shot
holdoff_cycles  in  16  dead time after a trigger in continuous mode
timeout_cycles  in  32  armed timeout; 0 = no timeout
state_prog_en  out  1  to trigger_system
state_prog_addr  out  STATEADDR_WIDTH  to trigger_system
state_prog_wr  out  1  to trigger_system
state_prog_data  out  18  to trigger_system
ts_rst  out  1  drives trigger_system rst
ts_trig  in  1  trigger_system trig_out
trig_out  out  1  gated 1-cycle trigger pulse
busy  out  1  high in LOAD, TERM and SETTLE
armed  out  1  high in ARMED
triggered  out  1  sticky; cleared on arm or load_start
timed_out  out  1  sticky; cleared on arm or load_start
trig_count  out  16  triggers since last load_start; saturates at 16'hFFFF

Behaviour:
- Reset values:
  - state IDLE, ts_rst=1, trig_out=0, entry_ready=0.
  - All prog_* outputs 0; all status flags 0; trig_count=0.
- States: IDLE, LOAD, TERM, SETTLE, ARMED, HOLDOFF.
- IDLE:
  - ts_rst=1.
  - load_start -> LOAD: wr_addr=0, count=min(num_entries, STATES-1), clear triggered, timed_out and trig_count.
  - arm -> SETTLE with post-settle target ARMED; clears triggered and timed_out.
  - load_start has priority over arm in the same cycle.
- LOAD:
  - state_prog_en=1; entry_ready=1 while wr_addr<count.
  - Each entry_valid&entry_ready cycle: state_prog_wr=1, state_prog_addr=wr_addr, state_prog_data=entry_data (combinational from the handshake), then wr_addr++.
  - When wr_addr==count -> TERM. count=0 goes directly to TERM.
- TERM: one cycle with state_prog_en=1, state_prog_wr=1, addr=wr_addr, data=18'h3FFFF -> SETTLE with post-settle target IDLE.
- SETTLE:
  - prog_en=0, ts_rst=1 for SETTLE_CYCLES, then go to the target.
  - The hold covers the RAM's registered-address read latency, so entry 0 data is valid before ts_rst falls.
- ARMED:
  - ts_rst=0; timeout counter runs from 0.
  - ts_trig=1:
    - trig_out=1 on the next cycle (1-cycle registered latency); triggered=1; trig_count++ (saturating).
    - Go to HOLDOFF if continuous, else IDLE.
  - Timeout counter reaching timeout_cycles (non-zero) -> timed_out=1, go to IDLE.
  - ts_trig and timeout in the same cycle: the trigger wins; timed_out is not set.
- HOLDOFF:
  - ts_rst=1 for max(holdoff_cycles, SETTLE_CYCLES) cycles, then ARMED with the timeout counter restarted.
  - ts_trig is ignored.
- disarm:
  - In LOAD, TERM, ARMED or HOLDOFF -> IDLE next cycle.
  - A load aborted by disarm writes no terminator; the RAM contents are undefined until the next full load.
  - disarm beats a simultaneous ts_trig: no trig_out.
- arm outside IDLE is ignored.
- load_start outside IDLE is ignored.
- Asynchronous rst mid-operation: all outputs go to reset values immediately; RAM contents are not touched.
- trig_out is never asserted while ts_rst=1.

Decomposition:
- Shared package: state enum and the terminator constant TRIG_TERMINATOR=18'h3FFFF.
- Shared package: entry field offsets (LOW 7:0, HIGH 16:8, STATE 17) and HIGH_INF=9'd511.
- One sub-module, seq_cycle_timer: a loadable down-counter with a done flag. It serves SETTLE, HOLDOFF and timeout, widened to 32 bits.

Test Plan:
- Load 3 entries with entry_valid stalled every other cycle:
  - prog writes at addr 0,1,2 with the matching data.
  - addr 3 gets 18'h3FFFF; busy falls after 4 SETTLE cycles.
- num_entries=63 with STATES=64: 63 writes, terminator at addr 63. num_entries=0: only the terminator at addr 0.
- Single shot: arm, ts_trig pulse 10 cycles later -> trig_out 1 cycle later, triggered=1, trig_count=1, state IDLE, ts_rst=1.
- Continuous, holdoff=20: 3 ts_trig pulses, one inside holdoff -> trig_count=2; that pulse produces no trig_out and ts_rst is high during it.
- timeout=100 with no trigger -> timed_out=1 at cycle 100, state IDLE. Repeat with ts_trig on cycle 100 -> triggered=1, timed_out=0.
- Asynchronous rst during LOAD, and disarm together with ts_trig in ARMED:
  - rst: all outputs reset without waiting for a clk edge.
  - disarm+ts_trig: trig_out stays 0, state IDLE.
